// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access stage: access widths,
// writeback exception codes, FSM states and the alignment check.
package mem_access_unit_pkg;

   // Access width encodings carried on exm_mem_width_i.
   localparam logic [1:0] MEM_B = 2'b00;
   localparam logic [1:0] MEM_H = 2'b01;
   localparam logic [1:0] MEM_W = 2'b10;

   // Exception codes reported on wb_exc_o.
   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_BUSERR   = 2'b10;

   // Bus access FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // True when the access can never reach the bus: a half on an odd
   // address, a word off a word boundary, or the reserved width code.
   function automatic logic is_misaligned(input logic [1:0] width,
                                          input logic [1:0] addr_lo);
      case (width)
         MEM_B:   return 1'b0;
         MEM_H:   return addr_lo[0];
         MEM_W:   return (addr_lo != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a right-aligned register value and a 32-bit
// little-endian bus word. Purely combinational so that an instruction-side
// unit can reuse it without inheriting any timing.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_width,
   input  logic        i_rw,
   input  logic        i_rdtype,
   input  logic [31:0] i_wr_data,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_lane [4];
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_lane[gi] = i_rdata[8*gi +: 8];
      end
   endgenerate

   assign w_byte = w_lane[i_addr_lo];
   assign w_half = i_addr_lo[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};

   // Store path: replicate the data into every lane and let the strobes
   // pick the lanes that are written. Loads write nothing.
   always_comb begin
      o_wdata = '0;
      o_wstrb = '0;
      if (i_rw) begin
         case (i_width)
            MEM_B: begin
               o_wdata = {4{i_wr_data[7:0]}};
               o_wstrb = 4'b0001 << i_addr_lo;
            end
            MEM_H: begin
               o_wdata = {2{i_wr_data[15:0]}};
               o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
            end
            MEM_W: begin
               o_wdata = i_wr_data;
               o_wstrb = 4'b1111;
            end
            default: begin
               o_wdata = '0;
               o_wstrb = '0;
            end
         endcase
      end
   end

   // Load path: pick the addressed lane and sign- or zero-extend it.
   always_comb begin
      o_load_data = i_rdata;
      case (i_width)
         MEM_B:   o_load_data = i_rdtype ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         MEM_H:   o_load_data = i_rdtype ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: o_load_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: runs one load/store at a time over a
// req/gnt/rvalid bus, stalls upstream while busy and emits a one-cycle
// registered writeback record per accepted instruction.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = 8'd255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        exm_valid_i,
   input  logic [31:0] exm_op_c_i,
   input  logic [4:0]  exm_reg_waddr_i,
   input  logic        exm_reg_we_i,
   input  logic        exm_mtype_i,
   input  logic        exm_mem_rw_i,
   input  logic [1:0]  exm_mem_width_i,
   input  logic [31:0] exm_mem_wr_data_i,
   input  logic        exm_mem_rdtype_i,
   output logic        mem_stall_o,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_wdata_o,
   output logic [3:0]  dbus_wstrb_o,
   input  logic        dbus_gnt_i,
   input  logic        dbus_rvalid_i,
   input  logic [31:0] dbus_rdata_i,
   output logic        wb_valid_o,
   output logic [31:0] wb_data_o,
   output logic [4:0]  wb_reg_waddr_o,
   output logic        wb_reg_we_o,
   output logic [1:0]  wb_exc_o
);

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_addr;
   logic [31:0] r_wr_data;
   logic [1:0]  r_width;
   logic        r_rdtype;
   logic        r_rw;
   logic        r_we;
   logic [4:0]  r_waddr;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_inc;

   logic        w_idle;
   logic        w_mem_rec;
   logic        w_illegal;
   logic        w_accept;
   logic        w_done;
   logic        w_timeout;
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic [31:0] w_load_data;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_mem_rec = exm_valid_i & exm_mtype_i;
   assign w_illegal = is_misaligned(exm_mem_width_i, exm_op_c_i[1:0]);
   assign w_accept  = w_idle & w_mem_rec & ~w_illegal;
   assign w_cnt_inc = r_cnt + 8'd1;

   // Lane steering works from the latched request so the bus stays stable
   // while the upstream record is being held.
   mem_lane_align u_lane (
      .i_addr_lo   (r_addr[1:0]),
      .i_width     (r_width),
      .i_rw        (r_rw),
      .i_rdtype    (r_rdtype),
      .i_wr_data   (r_wr_data),
      .i_rdata     (dbus_rdata_i),
      .o_wdata     (w_wdata),
      .o_wstrb     (w_wstrb),
      .o_load_data (w_load_data)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next state, completion/timeout detection, stall and bus outputs.
   always_comb begin
      w_state_next = r_state;
      w_done       = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_next = ST_REQ;
         end
         ST_REQ: begin
            // A response arriving with the grant finishes the access at once;
            // a response without a grant belongs to nobody and is dropped.
            if (dbus_gnt_i && dbus_rvalid_i) begin
               w_state_next = ST_IDLE;
               w_done       = 1'b1;
            end else if (dbus_gnt_i) begin
               w_state_next = ST_WAIT;
            end else if (w_cnt_inc == TIMEOUT) begin
               w_state_next = ST_IDLE;
               w_timeout    = 1'b1;
            end
         end
         ST_WAIT: begin
            if (dbus_rvalid_i) begin
               w_state_next = ST_IDLE;
               w_done       = 1'b1;
            end else if (w_cnt_inc == TIMEOUT) begin
               w_state_next = ST_IDLE;
               w_timeout    = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase

      // A timeout retires the record just like a response does, so upstream
      // must be released in that cycle or the same record would be replayed.
      mem_stall_o  = ~rst & ((~w_idle & ~w_done & ~w_timeout) | w_accept);

      dbus_req_o   = (r_state == ST_REQ);
      dbus_we_o    = dbus_req_o & r_rw;
      dbus_addr_o  = dbus_req_o ? {r_addr[31:2], 2'b00} : 32'd0;
      dbus_wdata_o = dbus_req_o ? w_wdata : 32'd0;
      dbus_wstrb_o = dbus_req_o ? w_wstrb : 4'd0;
   end

   // Wait counter: restarts when an access is accepted and again on grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_cnt <= 8'd0;
      else if (w_idle)                        r_cnt <= 8'd0;
      else if (r_state == ST_REQ && dbus_gnt_i) r_cnt <= 8'd0;
      else                                    r_cnt <= w_cnt_inc;
   end

   // Capture the memory request when it is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr    <= 32'd0;
         r_wr_data <= 32'd0;
         r_width   <= MEM_B;
         r_rdtype  <= 1'b0;
         r_rw      <= 1'b0;
         r_we      <= 1'b0;
         r_waddr   <= 5'd0;
      end else if (w_accept) begin
         r_addr    <= exm_op_c_i;
         r_wr_data <= exm_mem_wr_data_i;
         r_width   <= exm_mem_width_i;
         r_rdtype  <= exm_mem_rdtype_i;
         r_rw      <= exm_mem_rw_i;
         r_we      <= exm_reg_we_i;
         r_waddr   <= exm_reg_waddr_i;
      end
   end

   // Writeback record: one-cycle pulse for ALU pass-through, rejected
   // accesses, completed accesses and bus timeouts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_o     <= 1'b0;
         wb_data_o      <= 32'd0;
         wb_reg_waddr_o <= 5'd0;
         wb_reg_we_o    <= 1'b0;
         wb_exc_o       <= EXC_NONE;
      end else begin
         wb_valid_o     <= 1'b0;
         wb_data_o      <= 32'd0;
         wb_reg_waddr_o <= 5'd0;
         wb_reg_we_o    <= 1'b0;
         wb_exc_o       <= EXC_NONE;
         if (w_idle && exm_valid_i && !exm_mtype_i) begin
            wb_valid_o     <= 1'b1;
            wb_data_o      <= exm_op_c_i;
            wb_reg_waddr_o <= exm_reg_waddr_i;
            wb_reg_we_o    <= exm_reg_we_i;
         end else if (w_idle && w_mem_rec && w_illegal) begin
            wb_valid_o     <= 1'b1;
            wb_reg_waddr_o <= exm_reg_waddr_i;
            wb_exc_o       <= EXC_MISALIGN;
         end else if (w_done) begin
            wb_valid_o     <= 1'b1;
            wb_data_o      <= r_rw ? 32'd0 : w_load_data;
            wb_reg_waddr_o <= r_waddr;
            wb_reg_we_o    <= r_we & ~r_rw;
         end else if (w_timeout) begin
            wb_valid_o     <= 1'b1;
            wb_reg_waddr_o <= r_waddr;
            wb_exc_o       <= EXC_BUSERR;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short bus timeout.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        exm_valid_i;
   logic [31:0] exm_op_c_i;
   logic [4:0]  exm_reg_waddr_i;
   logic        exm_reg_we_i;
   logic        exm_mtype_i;
   logic        exm_mem_rw_i;
   logic [1:0]  exm_mem_width_i;
   logic [31:0] exm_mem_wr_data_i;
   logic        exm_mem_rdtype_i;
   logic        mem_stall_o;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [31:0] dbus_wdata_o;
   logic [3:0]  dbus_wstrb_o;
   logic        dbus_gnt_i;
   logic        dbus_rvalid_i;
   logic [31:0] dbus_rdata_i;
   logic        wb_valid_o;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_reg_waddr_o;
   logic        wb_reg_we_o;
   logic [1:0]  wb_exc_o;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_unit #(.TIMEOUT(8'd4)) dut (
      .clk               (clk),
      .rst               (rst),
      .exm_valid_i       (exm_valid_i),
      .exm_op_c_i        (exm_op_c_i),
      .exm_reg_waddr_i   (exm_reg_waddr_i),
      .exm_reg_we_i      (exm_reg_we_i),
      .exm_mtype_i       (exm_mtype_i),
      .exm_mem_rw_i      (exm_mem_rw_i),
      .exm_mem_width_i   (exm_mem_width_i),
      .exm_mem_wr_data_i (exm_mem_wr_data_i),
      .exm_mem_rdtype_i  (exm_mem_rdtype_i),
      .mem_stall_o       (mem_stall_o),
      .dbus_req_o        (dbus_req_o),
      .dbus_we_o         (dbus_we_o),
      .dbus_addr_o       (dbus_addr_o),
      .dbus_wdata_o      (dbus_wdata_o),
      .dbus_wstrb_o      (dbus_wstrb_o),
      .dbus_gnt_i        (dbus_gnt_i),
      .dbus_rvalid_i     (dbus_rvalid_i),
      .dbus_rdata_i      (dbus_rdata_i),
      .wb_valid_o        (wb_valid_o),
      .wb_data_o         (wb_data_o),
      .wb_reg_waddr_o    (wb_reg_waddr_o),
      .wb_reg_we_o       (wb_reg_we_o),
      .wb_exc_o          (wb_exc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rec(input logic mtype, input logic [31:0] op_c, input logic rw,
                          input logic [1:0] width, input logic [31:0] wdata, input logic rdtype);
      exm_valid_i       = 1'b1;
      exm_mtype_i       = mtype;
      exm_op_c_i        = op_c;
      exm_reg_waddr_i   = 5'd9;
      exm_reg_we_i      = 1'b1;
      exm_mem_rw_i      = rw;
      exm_mem_width_i   = width;
      exm_mem_wr_data_i = wdata;
      exm_mem_rdtype_i  = rdtype;
   endtask

   // One bus access with gnt on the first req cycle; rvalid either with the
   // grant (same_cycle) or on the following cycle.
   task automatic do_access(input string tag, input logic [31:0] addr, input logic rw,
                            input logic [1:0] width, input logic [31:0] wdata, input logic rdtype,
                            input logic [31:0] rdata, input logic same_cycle,
                            input logic [31:0] exp_baddr, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_wstrb, input logic [31:0] exp_wb,
                            input logic exp_we);
      set_rec(1'b1, addr, rw, width, wdata, rdtype);
      #1;
      check({tag, " stall c0"}, 32'(mem_stall_o), 32'd1);
      check({tag, " req c0"}, 32'(dbus_req_o), 32'd0);
      tick();
      dbus_gnt_i    = 1'b1;
      dbus_rvalid_i = same_cycle;
      dbus_rdata_i  = rdata;
      #1;
      check({tag, " req c1"}, 32'(dbus_req_o), 32'd1);
      check({tag, " addr"}, dbus_addr_o, exp_baddr);
      check({tag, " bus we"}, 32'(dbus_we_o), 32'(rw));
      check({tag, " wstrb"}, 32'(dbus_wstrb_o), 32'(exp_wstrb));
      if (rw) check({tag, " wdata"}, dbus_wdata_o, exp_wdata);
      check({tag, " stall c1"}, 32'(mem_stall_o), same_cycle ? 32'd0 : 32'd1);
      if (!same_cycle) begin
         tick();
         dbus_gnt_i    = 1'b0;
         dbus_rvalid_i = 1'b1;
         #1;
         check({tag, " stall c2"}, 32'(mem_stall_o), 32'd0);
         check({tag, " req c2"}, 32'(dbus_req_o), 32'd0);
      end
      exm_valid_i = 1'b0;
      tick();
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
      check({tag, " wb_valid"}, 32'(wb_valid_o), 32'd1);
      check({tag, " wb_data"}, wb_data_o, exp_wb);
      check({tag, " wb_we"}, 32'(wb_reg_we_o), 32'(exp_we));
      check({tag, " wb_waddr"}, 32'(wb_reg_waddr_o), 32'd9);
      check({tag, " wb_exc"}, 32'(wb_exc_o), 32'd0);
      tick();
      check({tag, " wb pulse"}, 32'(wb_valid_o), 32'd0);
      $display("txn %s addr=%08h wb_data=%08h", tag, addr, exp_wb);
   endtask

   // Record that must bypass the bus and retire next cycle.
   task automatic do_direct(input string tag, input logic mtype, input logic [31:0] op_c,
                            input logic [1:0] width, input logic [31:0] exp_data,
                            input logic exp_we, input logic [1:0] exp_exc);
      set_rec(mtype, op_c, 1'b0, width, 32'd0, 1'b0);
      #1;
      check({tag, " stall"}, 32'(mem_stall_o), 32'd0);
      check({tag, " req"}, 32'(dbus_req_o), 32'd0);
      tick();
      exm_valid_i = 1'b0;
      check({tag, " wb_valid"}, 32'(wb_valid_o), 32'd1);
      check({tag, " wb_exc"}, 32'(wb_exc_o), 32'(exp_exc));
      check({tag, " wb_we"}, 32'(wb_reg_we_o), 32'(exp_we));
      check({tag, " wb_data"}, wb_data_o, exp_data);
      check({tag, " req after"}, 32'(dbus_req_o), 32'd0);
      tick();
      check({tag, " wb pulse"}, 32'(wb_valid_o), 32'd0);
      $display("txn %s op_c=%08h exc=%0d", tag, op_c, exp_exc);
   endtask

   initial begin
      rst               = 1'b1;
      exm_valid_i       = 1'b0;
      exm_op_c_i        = 32'd0;
      exm_reg_waddr_i   = 5'd0;
      exm_reg_we_i      = 1'b0;
      exm_mtype_i       = 1'b0;
      exm_mem_rw_i      = 1'b0;
      exm_mem_width_i   = 2'b00;
      exm_mem_wr_data_i = 32'd0;
      exm_mem_rdtype_i  = 1'b0;
      dbus_gnt_i        = 1'b0;
      dbus_rvalid_i     = 1'b0;
      dbus_rdata_i      = 32'd0;
      tick();
      tick();
      check("rst wb_valid", 32'(wb_valid_o), 32'd0);
      check("rst wb_data", wb_data_o, 32'd0);
      check("rst wb_exc", 32'(wb_exc_o), 32'd0);
      check("rst req", 32'(dbus_req_o), 32'd0);
      check("rst stall", 32'(mem_stall_o), 32'd0);
      check("rst addr", dbus_addr_o, 32'd0);
      check("rst wstrb", 32'(dbus_wstrb_o), 32'd0);
      rst = 1'b0;
      tick();
      $display("txn reset released");

      do_access("ld_w",    32'h100, 1'b0, 2'b10, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0,
                32'h100, 32'd0, 4'b0000, 32'hDEADBEEF, 1'b1);
      do_access("ld_b_s",  32'h103, 1'b0, 2'b00, 32'd0, 1'b0, 32'h80112233, 1'b0,
                32'h100, 32'd0, 4'b0000, 32'hFFFFFF80, 1'b1);
      do_access("ld_b_z",  32'h103, 1'b0, 2'b00, 32'd0, 1'b1, 32'h80112233, 1'b0,
                32'h100, 32'd0, 4'b0000, 32'h00000080, 1'b1);
      do_access("st_h",    32'h022, 1'b1, 2'b01, 32'h0000ABCD, 1'b0, 32'd0, 1'b0,
                32'h020, 32'hABCDABCD, 4'b1100, 32'd0, 1'b0);
      do_access("st_b",    32'h101, 1'b1, 2'b00, 32'h12345677, 1'b0, 32'd0, 1'b0,
                32'h100, 32'h77777777, 4'b0010, 32'd0, 1'b0);
      do_access("st_w",    32'h040, 1'b1, 2'b10, 32'hCAFEF00D, 1'b0, 32'd0, 1'b0,
                32'h040, 32'hCAFEF00D, 4'b1111, 32'd0, 1'b0);
      do_access("ld_h_s",  32'h002, 1'b0, 2'b01, 32'd0, 1'b0, 32'h80011234, 1'b0,
                32'h000, 32'd0, 4'b0000, 32'hFFFF8001, 1'b1);
      do_access("ld_h_z",  32'h000, 1'b0, 2'b01, 32'd0, 1'b1, 32'h80019234, 1'b0,
                32'h000, 32'd0, 4'b0000, 32'h00009234, 1'b1);
      do_access("ld_same", 32'h300, 1'b0, 2'b10, 32'd0, 1'b0, 32'h01020304, 1'b1,
                32'h300, 32'd0, 4'b0000, 32'h01020304, 1'b1);

      do_direct("alu",      1'b0, 32'h12345678, 2'b00, 32'h12345678, 1'b1, 2'b00);
      do_direct("mis_w",    1'b1, 32'h00000102, 2'b10, 32'd0, 1'b0, 2'b01);
      do_direct("mis_h",    1'b1, 32'h00000101, 2'b01, 32'd0, 1'b0, 2'b01);
      do_direct("bad_wid",  1'b1, 32'h00000000, 2'b11, 32'd0, 1'b0, 2'b01);

      // Grant withheld: four cycles in REQ, then a bus-error record.
      set_rec(1'b1, 32'h200, 1'b0, 2'b10, 32'd0, 1'b0);
      #1;
      check("tmo stall c0", 32'(mem_stall_o), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 4) exm_valid_i = 1'b0;
         #1;
         check($sformatf("tmo req c%0d", i), 32'(dbus_req_o), 32'd1);
         check($sformatf("tmo wb c%0d", i), 32'(wb_valid_o), 32'd0);
         if (i < 4) check($sformatf("tmo stall c%0d", i), 32'(mem_stall_o), 32'd1);
      end
      tick();
      check("tmo wb_valid", 32'(wb_valid_o), 32'd1);
      check("tmo wb_exc", 32'(wb_exc_o), 32'd2);
      check("tmo wb_we", 32'(wb_reg_we_o), 32'd0);
      check("tmo req idle", 32'(dbus_req_o), 32'd0);
      check("tmo stall idle", 32'(mem_stall_o), 32'd0);
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'h55555555;
      tick();
      dbus_rvalid_i = 1'b0;
      check("tmo wb pulse", 32'(wb_valid_o), 32'd0);
      tick();
      check("stray rvalid", 32'(wb_valid_o), 32'd0);
      $display("txn timeout addr=00000200");

      // Reset while waiting for rvalid.
      set_rec(1'b1, 32'h400, 1'b0, 2'b10, 32'd0, 1'b0);
      tick();
      dbus_gnt_i = 1'b1;
      tick();
      dbus_gnt_i = 1'b0;
      #1;
      check("rst_wait in WAIT", 32'(mem_stall_o), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_wait req", 32'(dbus_req_o), 32'd0);
      check("rst_wait stall", 32'(mem_stall_o), 32'd0);
      exm_valid_i = 1'b0;
      tick();
      check("rst_wait wb0", 32'(wb_valid_o), 32'd0);
      #2;
      rst = 1'b0;
      tick();
      check("rst_wait wb1", 32'(wb_valid_o), 32'd0);
      $display("txn reset in WAIT");
      do_access("after_rst", 32'h404, 1'b0, 2'b10, 32'd0, 1'b0, 32'hA5A5F00F, 1'b0,
                32'h404, 32'd0, 4'b0000, 32'hA5A5F00F, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage of core_version_0. Takes the registered execute-stage result and memory-request fields, runs loads and stores against the data bus with a req/gnt/rvalid handshake, and applies byte/half alignment and load sign/zero extension. Stalls the upstream pipeline while an access is outstanding and hands a registered writeback record to the WB stage.

## Interface
- TIMEOUT, 255: maximum cycles waiting for gnt or rvalid before aborting with a bus error; 8-bit counter.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- exm_valid_i  in  1  upstream record valid.
- exm_op_c_i  in  32  ALU result; also the memory address.
- exm_reg_waddr_i  in  5  destination register.
- exm_reg_we_i  in  1  register write enable.
- exm_mtype_i  in  1  memory instruction.
- exm_mem_rw_i  in  1  1 = store, 0 = load.
- exm_mem_width_i  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- exm_mem_wr_data_i  in  32  store data, right-aligned.
- exm_mem_rdtype_i  in  1  0 = sign-extend load, 1 = zero-extend load.
- mem_stall_o  out  1  hold upstream registers.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  bus write.
- dbus_addr_o  out  32  word address, bits [1:0] = 0.
- dbus_wdata_o  out  32  lane-replicated store data.
- dbus_wstrb_o  out  4  byte strobes.
- dbus_gnt_i  in  1  request accepted.
- dbus_rvalid_i  in  1  response valid; sent for both loads and stores.
- dbus_rdata_i  in  32  read word.
- wb_valid_o  out  1  writeback record valid.
- wb_data_o  out  32  writeback value.
- wb_reg_waddr_o  out  5  destination register.
- wb_reg_we_o  out  1  register write enable; forced to 0 on any exception.
- wb_exc_o  out  2  00 none, 01 misaligned or illegal width, 10 bus timeout.

## Operation
- FSM states:
  - IDLE: no access outstanding.
  - REQ: dbus_req_o = 1, waiting for gnt.
  - WAIT: waiting for rvalid.
- Non-memory record (valid, mtype = 0): registered to the wb_* outputs next cycle. wb_data_o = op_c. No stall.
- Misaligned access: half with addr[0] = 1, or word with addr[1:0] != 0. Also width = 11.
  - No bus activity.
  - Next cycle: wb_valid_o = 1, wb_exc_o = 01, wb_reg_we_o = 0.
- Legal memory record in IDLE:
  - Go to REQ.
  - Latch addr[1:0], width, rdtype, rw, waddr and we into internal registers.
- REQ:
  - Bus outputs are driven from the latched values and stay stable until gnt.
  - gnt: go to WAIT and clear the counter.
- WAIT:
  - rvalid: go to IDLE and emit the wb record next edge.
  - Load result: the lane selected by latched addr[1:0] (half lane = addr[1]), extended per rdtype.
  - Store result: wb_data_o = 0, wb_reg_we_o = 0.
- Timeout: counter reaches TIMEOUT in REQ or WAIT. Go to IDLE and emit a record with wb_exc_o = 10 and we = 0. A later stray rvalid in IDLE is ignored.
- Store lanes:
  - byte: wdata = {4{d[7:0]}}, wstrb = 0001 << addr[1:0].
  - half: wdata = {2{d[15:0]}}, wstrb = 0011 << {addr[1],1'b0}.
  - word: wdata = d, wstrb = 1111.
- Loads drive wstrb = 0000.
- mem_stall_o = 1 when:
  - state != IDLE and the response is not completing this cycle, or
  - state == IDLE and a legal memory record is presented.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, counter 0.
- Latency:
  - Non-memory or exception record: 1 cycle.
  - Memory access with gnt and rvalid each arriving the cycle after they become possible: 3 cycles from acceptance to wb_valid_o. The record is accepted in IDLE, req is driven in the next cycle, and wb is registered after rvalid.
- gnt and rvalid in the same cycle while in REQ: treat as completion and go directly to IDLE.
- rvalid in REQ without gnt: ignored.
- wb_valid_o is a single-cycle pulse per record. WB never backpressures.
- While mem_stall_o = 1, the exm_* inputs are held and not re-sampled.
- rst mid-access: bus outputs drop to 0 immediately. The in-flight record is lost and no wb pulse is produced.

## Structure
- Add to the shared define.v:
  - width encodings: MEM_B, MEM_H, MEM_W.
  - exception codes: EXC_NONE, EXC_MISALIGN, EXC_BUSERR.
  - FSM state constants.
- One combinational sub-module: mem_lane_align. It does store lane replication and strobe generation, plus load lane extraction and extension. It is shared with a future instruction-side unit.

## Test plan
- Word load, addr 0x100, gnt and rvalid one cycle after req, rdata 0xDEADBEEF → wb_data_o = 0xDEADBEEF, we = 1. Stall held for 2 cycles.
- Signed byte load, addr 0x103, rdata 0x80112233 → 0xFFFFFF80. Same access with rdtype = 1 → 0x00000080.
- Half store, addr 0x22, data 0x0000ABCD → dbus_addr_o = 0x20, wdata = 0xABCDABCD, wstrb = 1100, wb_reg_we_o = 0.
- Word load at 0x102 → no dbus_req_o, wb_exc_o = 01 after 1 cycle, no stall.
- gnt withheld, TIMEOUT = 4 → after 4 cycles in REQ: wb_exc_o = 10, state IDLE, stall released.
- rst asserted while in WAIT → dbus_req_o and mem_stall_o are 0 in the same cycle. No wb_valid_o. The next record completes normally.
